alu_regfile_datapath: RTL and testbench
=======================================

Name: alu_regfile_datapath

Overview:
- Execution core of the 16-bit multicycle MIPS-style CPU: 16x16 register file, ALU-control decoder and 16-bit ALU in one block.
- External operand muxes (A/B select) feed the ALU; the main FSM supplies the op_alu class and write enables.
- Register-file debug read port drives the board hex displays.

Parameters:
- NREGS, 16, number of registers (address width fixed at 4 bits).
- WIDTH, 16, datapath width in bits.

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears register file and alu_out
- reg_write  in  1  register-file write enable
- rd_addr_a  in  4  read port A address
- rd_addr_b  in  4  read port B address
- wr_addr  in  4  write address
- wr_data  in  16  write data
- rd_data_a  out  16  read port A data
- rd_data_b  out  16  read port B data
- dbg_addr  in  4  debug read address (switches)
- dbg_data  out  16  debug read data
- op_alu  in  2  ALU op class from FSM
- opcode  in  4  instruction bits [15:12]
- src_a  in  16  ALU operand A
- src_b  in  16  ALU operand B
- alu_ctl  out  4  decoded ALU function
- alu_result  out  16  combinational ALU result
- alu_out  out  16  registered ALU result
- zero  out  1  alu_result == 0
- overflow  out  1  signed overflow on add/sub

Behaviour:
- Register file:
  - 16 entries of 16 bits.
  - Write on rising clock when reg_write=1; writes to address 0 are ignored.
  - Register 0 always reads 0x0000.
  - Reads are combinational and asynchronous.
  - Without bypass, a read of the address being written returns the old value until the edge.
  - Reset clears all entries to 0 asynchronously.
- ALU control (combinational), op_alu to alu_ctl:
  - 00 -> ADD (address and PC increment).
  - 01 -> SUB (beq compare).
  - 10 -> decode opcode: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOR, 0110 SLT, 0111 SLL, 1010 ADD (addi), 1011 SRL.
  - 10 with any other opcode -> ADD.
  - 11 -> PASSB.
- ALU function codes and results:
  - 0 ADD: a+b, modulo 2^16.
  - 1 SUB: a-b, modulo 2^16.
  - 2 AND, 3 OR, 4 XOR, 5 NOR: bitwise.
  - 6 SLT: 1 if signed a < signed b, else 0.
  - 7 SLL: a << b[3:0].
  - 8 SRL: a >> b[3:0], zero fill.
  - 9 PASSB: b.
  - Unused codes give 0.
- Flags:
  - zero = (alu_result == 0), all functions.
  - overflow = signed overflow for ADD/SUB only, 0 otherwise. ADD: operands same sign, result sign differs. SUB: operands differ in sign, result sign differs from a.
- alu_out:
  - Captures alu_result on every rising clock; no enable.
  - Reset value 0x0000.
  - Latency 1 cycle from operands to alu_out; alu_result and zero are same-cycle combinational.
- Reset:
  - Reset asserted mid-write: write is lost, register stays 0.
  - Release takes effect at the next clock edge.
- Debug port:
  - dbg_data is a combinational read of dbg_addr.
  - Has the same r0 and bypass rules as read ports A/B.

Optional Feature:
- Macro DP_BYPASS_EN.
- Defined: when reg_write=1 and a read address (A, B or debug) equals wr_addr≠0, that port returns wr_data in the same cycle (write-through forwarding).
- Undefined: reads return stored contents only; new data is visible after the clock edge.

Test Plan:
- Reset -> all of rd_data_a, rd_data_b, dbg_data and alu_out read 0x0000 for every address.
- Write 0x1234 to r5, then r0 with 0xFFFF; read A=5, B=0 -> 0x1234 and 0x0000; dbg_addr=5 -> 0x1234.
- op_alu=10, opcode=0001, a=0x0005, b=0x0005 -> alu_ctl=1, alu_result=0x0000, zero=1; alu_out=0x0000 after one edge.
- op_alu=00, a=0x7FFF, b=0x0001 -> result 0x8000, overflow=1; op_alu=01, a=0x8000, b=0x0001 -> 0x7FFF, overflow=1.
- op_alu=10: opcode 0110, a=0xFFFF, b=0x0001 -> 0x0001; opcode 0111, a=0x0003, b=0x0004 -> 0x0030; opcode 1011, a=0x8000, b=0x000F -> 0x0001; opcode 0101, a=0x00F0, b=0x0F00 -> 0xF00F.
- Write r3=0xABCD with read A=3 in the same cycle -> 0xABCD before the edge if DP_BYPASS_EN is defined, old value 0x0000 otherwise; assert reset mid-cycle -> r3 stays 0.

Source files
------------

// File: rtl/alu_regfile_datapath.sv
// Execution core: 16x16 register file, ALU-control decoder and 16-bit ALU with registered result.
// Optional write-through forwarding on all read ports when DP_BYPASS_EN is defined.
module alu_regfile_datapath #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             reg_write,
  input  logic [3:0]       rd_addr_a,
  input  logic [3:0]       rd_addr_b,
  input  logic [3:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  input  logic [1:0]       op_alu,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned MSB = WIDTH - 1;

  typedef enum logic [3:0] {
    FN_ADD   = 4'd0,
    FN_SUB   = 4'd1,
    FN_AND   = 4'd2,
    FN_OR    = 4'd3,
    FN_XOR   = 4'd4,
    FN_NOR   = 4'd5,
    FN_SLT   = 4'd6,
    FN_SLL   = 4'd7,
    FN_SRL   = 4'd8,
    FN_PASSB = 4'd9
  } alu_fn_e;

  logic [WIDTH-1:0] regs [NREGS];
  logic             byp_a;
  logic             byp_b;
  logic             byp_dbg;
  alu_fn_e          fn;

  // Register storage; r0 is never written so it stays zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (reg_write && (wr_addr != 4'd0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

`ifdef DP_BYPASS_EN
  assign byp_a   = reg_write && (rd_addr_a == wr_addr);
  assign byp_b   = reg_write && (rd_addr_b == wr_addr);
  assign byp_dbg = reg_write && (dbg_addr  == wr_addr);
`else
  assign byp_a   = 1'b0;
  assign byp_b   = 1'b0;
  assign byp_dbg = 1'b0;
`endif

  assign rd_data_a = (rd_addr_a == 4'd0) ? '0 : (byp_a   ? wr_data : regs[rd_addr_a]);
  assign rd_data_b = (rd_addr_b == 4'd0) ? '0 : (byp_b   ? wr_data : regs[rd_addr_b]);
  assign dbg_data  = (dbg_addr  == 4'd0) ? '0 : (byp_dbg ? wr_data : regs[dbg_addr]);

  // ALU-control decode from FSM op class and instruction opcode
  always_comb begin
    fn = FN_ADD;
    case (op_alu)
      2'b00: fn = FN_ADD;
      2'b01: fn = FN_SUB;
      2'b10: begin
        case (opcode)
          4'b0000: fn = FN_ADD;
          4'b0001: fn = FN_SUB;
          4'b0010: fn = FN_AND;
          4'b0011: fn = FN_OR;
          4'b0100: fn = FN_XOR;
          4'b0101: fn = FN_NOR;
          4'b0110: fn = FN_SLT;
          4'b0111: fn = FN_SLL;
          4'b1010: fn = FN_ADD;
          4'b1011: fn = FN_SRL;
          default: fn = FN_ADD;
        endcase
      end
      default: fn = FN_PASSB;
    endcase
  end

  assign alu_ctl = fn;

  // ALU datapath and flags
  always_comb begin
    alu_result = '0;
    overflow   = 1'b0;
    case (fn)
      FN_ADD: begin
        alu_result = src_a + src_b;
        overflow   = (src_a[MSB] == src_b[MSB]) && (alu_result[MSB] != src_a[MSB]);
      end
      FN_SUB: begin
        alu_result = src_a - src_b;
        overflow   = (src_a[MSB] != src_b[MSB]) && (alu_result[MSB] != src_a[MSB]);
      end
      FN_AND:   alu_result = src_a & src_b;
      FN_OR:    alu_result = src_a | src_b;
      FN_XOR:   alu_result = src_a ^ src_b;
      FN_NOR:   alu_result = ~(src_a | src_b);
      FN_SLT:   alu_result = ($signed(src_a) < $signed(src_b)) ? WIDTH'(1) : '0;
      FN_SLL:   alu_result = src_a << src_b[3:0];
      FN_SRL:   alu_result = src_a >> src_b[3:0];
      FN_PASSB: alu_result = src_b;
      default:  alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) alu_out <= '0;
    else       alu_out <= alu_result;
  end

endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Scoreboard bench for alu_regfile_datapath: stimulus queues expectations, negedge monitor checks them.
module tb_alu_regfile_datapath;

  localparam int S_RDA = 0, S_RDB = 1, S_DBG = 2, S_CTL = 3,
                 S_RES = 4, S_OUT = 5, S_ZERO = 6, S_OVF = 7;

  typedef struct {
    int          cyc;
    int          sig;
    logic [15:0] exp;
    string       name;
  } item_t;

  logic        clock, reset, reg_write;
  logic [3:0]  rd_addr_a, rd_addr_b, wr_addr, dbg_addr, opcode;
  logic [15:0] wr_data, rd_data_a, rd_data_b, dbg_data;
  logic [1:0]  op_alu;
  logic [15:0] src_a, src_b, alu_result, alu_out;
  logic [3:0]  alu_ctl;
  logic        zero, overflow;

  item_t       sb[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] mon_act;
  logic [15:0] byp_exp;

  alu_regfile_datapath dut (
    .clock(clock), .reset(reset), .reg_write(reg_write),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .op_alu(op_alu), .opcode(opcode), .src_a(src_a), .src_b(src_b),
    .alu_ctl(alu_ctl), .alu_result(alu_result), .alu_out(alu_out),
    .zero(zero), .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] actual(input int sig);
    case (sig)
      S_RDA:   return rd_data_a;
      S_RDB:   return rd_data_b;
      S_DBG:   return dbg_data;
      S_CTL:   return {12'h000, alu_ctl};
      S_RES:   return alu_result;
      S_OUT:   return alu_out;
      S_ZERO:  return {15'h0000, zero};
      default: return {15'h0000, overflow};
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle
  always @(negedge clock) begin
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        mon_act = actual(sb[i].sig);
        n_cmp++;
        if (mon_act !== sb[i].exp) begin
          n_bad++;
          $display("FAIL %s: got 0x%h, want 0x%h (cycle %0d)", sb[i].name, mon_act, sb[i].exp, cyc);
        end
        sb.delete(i);
      end
    end
  end

  task automatic push(input int sig, input logic [15:0] exp, input string name, input int dly);
    item_t it;
    it.cyc = cyc + dly; it.sig = sig; it.exp = exp; it.name = name;
    sb.push_back(it);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic alu_vec(input logic [1:0] op, input logic [3:0] opc, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] ctl, input logic [15:0] res,
                         input logic ovf, input string name);
    step();
    op_alu = op; opcode = opc; src_a = a; src_b = b;
    push(S_CTL,  {12'h000, ctl}, {name, ".ctl"}, 0);
    push(S_RES,  res,            {name, ".res"}, 0);
    push(S_ZERO, {15'h0000, (res == 16'h0000)}, {name, ".zero"}, 0);
    push(S_OVF,  {15'h0000, ovf}, {name, ".ovf"}, 0);
    push(S_OUT,  res,            {name, ".alu_out"}, 1);
  endtask

  initial begin
    reset = 1'b1; reg_write = 1'b0; rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0;
    wr_data = '0; dbg_addr = '0; op_alu = 2'b00; opcode = '0; src_a = '0; src_b = '0;

    // Reset state
    step();
    src_a = 16'h1111; src_b = 16'h2222;
    push(S_OUT, 16'h0000, "rst.alu_out_held", 1);
    step();
    src_a = '0; src_b = '0;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      rd_addr_a = 4'(i); rd_addr_b = 4'(i); dbg_addr = 4'(i);
      push(S_RDA, 16'h0000, $sformatf("rst.rda%0d", i), 0);
      push(S_RDB, 16'h0000, $sformatf("rst.rdb%0d", i), 0);
      push(S_DBG, 16'h0000, $sformatf("rst.dbg%0d", i), 0);
    end

    // r5 write, r0 write ignored
    step(); reg_write = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234;
    step(); wr_addr = 4'd0; wr_data = 16'hFFFF;
    step(); reg_write = 1'b0; rd_addr_a = 4'd5; rd_addr_b = 4'd0; dbg_addr = 4'd5;
    push(S_RDA, 16'h1234, "wr.r5_a", 0);
    push(S_RDB, 16'h0000, "wr.r0_b", 0);
    push(S_DBG, 16'h1234, "wr.r5_dbg", 0);
    step(); rd_addr_a = 4'd0; dbg_addr = 4'd0;
    push(S_RDA, 16'h0000, "wr.r0_a", 0);
    push(S_DBG, 16'h0000, "wr.r0_dbg", 0);

    // ALU vectors: op, opcode, a, b, ctl, result, overflow
    alu_vec(2'b00, 4'h0, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 1'b1, "add_ovf");
    alu_vec(2'b01, 4'h0, 16'h8000, 16'h0001, 4'd1, 16'h7FFF, 1'b1, "sub_ovf");
    alu_vec(2'b10, 4'h1, 16'h0005, 16'h0005, 4'd1, 16'h0000, 1'b0, "sub_zero");
    alu_vec(2'b00, 4'h0, 16'h0001, 16'h0001, 4'd0, 16'h0002, 1'b0, "add_plain");
    alu_vec(2'b10, 4'h6, 16'hFFFF, 16'h0001, 4'd6, 16'h0001, 1'b0, "slt_neg");
    alu_vec(2'b10, 4'h6, 16'h0001, 16'hFFFF, 4'd6, 16'h0000, 1'b0, "slt_pos");
    alu_vec(2'b10, 4'h7, 16'h0003, 16'h0004, 4'd7, 16'h0030, 1'b0, "sll");
    alu_vec(2'b10, 4'hB, 16'h8000, 16'h000F, 4'd8, 16'h0001, 1'b0, "srl");
    alu_vec(2'b10, 4'h5, 16'h00F0, 16'h0F00, 4'd5, 16'hF00F, 1'b0, "nor");
    alu_vec(2'b10, 4'h2, 16'hFF0F, 16'h0FF0, 4'd2, 16'h0F00, 1'b0, "and");
    alu_vec(2'b10, 4'h3, 16'hFF0F, 16'h0FF0, 4'd3, 16'hFFFF, 1'b0, "or");
    alu_vec(2'b10, 4'h4, 16'hFF0F, 16'h0FF0, 4'd4, 16'hF0FF, 1'b0, "xor");
    alu_vec(2'b10, 4'hA, 16'h7000, 16'h1000, 4'd0, 16'h8000, 1'b1, "addi");
    alu_vec(2'b10, 4'hC, 16'h0010, 16'h0020, 4'd0, 16'h0030, 1'b0, "undef_opc");
    alu_vec(2'b11, 4'h1, 16'hFFFF, 16'h5A5A, 4'd9, 16'h5A5A, 1'b0, "passb");
    alu_vec(2'b11, 4'h0, 16'h1234, 16'h0000, 4'd9, 16'h0000, 1'b0, "passb_zero");

    // Same-cycle write and read of r3
`ifdef DP_BYPASS_EN
    byp_exp = 16'hABCD;
`else
    byp_exp = 16'h0000;
`endif
    step();
    reg_write = 1'b1; wr_addr = 4'd3; wr_data = 16'hABCD; rd_addr_a = 4'd3; dbg_addr = 4'd3;
    push(S_RDA, byp_exp, "byp.r3_a", 0);
    push(S_DBG, byp_exp, "byp.r3_dbg", 0);
    step(); reg_write = 1'b0;
    push(S_RDA, 16'hABCD, "byp.r3_after", 0);

    // Reset asserted mid-write: write lost, r3 cleared
    step(); reg_write = 1'b1; wr_addr = 4'd3; wr_data = 16'h1111;
    #2 reset = 1'b1;
    step(); reg_write = 1'b0;
    push(S_RDA, 16'h0000, "rstmid.r3_held", 0);
    push(S_OUT, 16'h0000, "rstmid.alu_out", 0);
    step(); reset = 1'b0;
    push(S_RDA, 16'h0000, "rstmid.r3_released", 0);
    push(S_DBG, 16'h0000, "rstmid.r3_dbg", 0);

    repeat (3) step();
    if (sb.size() != 0) begin
      n_bad += int'(sb.size());
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
